key_tracker: RTL and testbench

//  Upstream of the ball motion block. Converts a stream of single-key press/release

---
 rtl/key_tracker.sv | 89 ++++++++
 tb/tb_key_tracker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_tracker.sv
// Two-slot held-key tracker: turns single-key press/release events into a 16-bit {slot1, slot0}
// keycode published once per frame. Slots that see no accepted event for too long are cleared.
module key_tracker #(
  parameter bit          FILTER_EN     = 1'b1,
  parameter int unsigned FRAME_TIMEOUT = 120
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        key_valid,
  input  logic        key_make,
  input  logic [7:0]  key_code,
  input  logic        frame_tick,
  output logic [15:0] keycode,
  output logic [1:0]  key_count,
  output logic        overflow
);

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [8:0] TIMEOUT_LIMIT = 9'(FRAME_TIMEOUT);

  logic [7:0] slot0, slot1, slot0_next, slot1_next;
  logic [7:0] timer, timer_next;
  logic       overflow_next;
  logic       is_wasd, accepted, hit, dropped;

  assign is_wasd  = (key_code == KEY_W) || (key_code == KEY_A) ||
                    (key_code == KEY_S) || (key_code == KEY_D);
  assign accepted = key_valid && (key_code != 8'h00) && (!FILTER_EN || is_wasd);
  assign hit      = (slot0 == key_code) || (slot1 == key_code);

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    slot0_next = slot0;
    slot1_next = slot1;
    timer_next = timer;
    dropped    = 1'b0;
    if (accepted) begin
      timer_next = 8'h00;
      if (key_make) begin
        if (!hit) begin
          if (slot0 == 8'h00)      slot0_next = key_code;
          else if (slot1 == 8'h00) slot1_next = key_code;
          else                     dropped    = 1'b1;
        end
      end else if (slot0 == key_code) begin
        // Compaction keeps a lone held key in slot0.
        slot0_next = slot1;
        slot1_next = 8'h00;
      end else if (slot1 == key_code) begin
        slot1_next = 8'h00;
      end
    end else if (frame_tick && (key_count != 2'd0)) begin
      if (({1'b0, timer} + 9'd1) == TIMEOUT_LIMIT) begin
        slot0_next = 8'h00;
        slot1_next = 8'h00;
        timer_next = 8'h00;
      end else begin
        timer_next = timer + 8'd1;
      end
    end
    // slot0 empty implies both slots empty, which is what releases the sticky flag.
    overflow_next = (slot0_next == 8'h00) ? 1'b0 : (overflow || dropped);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      slot0    <= 8'h00;
      slot1    <= 8'h00;
      timer    <= 8'h00;
      overflow <= 1'b0;
      keycode  <= 16'h0000;
    end else begin
      slot0    <= slot0_next;
      slot1    <= slot1_next;
      timer    <= timer_next;
      overflow <= overflow_next;
      if (frame_tick) keycode <= {slot1_next, slot0_next};
    end
  end

  assign key_count = {1'b0, slot0 != 8'h00} + {1'b0, slot1 != 8'h00};

endmodule

// File: tb/tb_key_tracker.sv
// Bench for key_tracker: two instances (WASD filter with a short timeout, unfiltered with the
// default timeout) share one stimulus stream and are compared against an ordered-list model.
module tb_key_tracker;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        key_valid, key_make, frame_tick;
  logic [7:0]  key_code;
  logic [15:0] keycode_a, keycode_b;
  logic [1:0]  key_count_a, key_count_b;
  logic        overflow_a, overflow_b;

  int checks = 0;
  int errors = 0;

  // Model state per instance: held keys in press order, sticky overflow, frames idle, published value.
  logic [7:0]  held [2][$];
  bit          ovf  [2];
  int          idle [2];
  logic [15:0] pub  [2];
  bit          filt [2] = '{1'b1, 1'b0};
  int          tmo  [2] = '{3, 120};

  key_tracker #(.FILTER_EN(1'b1), .FRAME_TIMEOUT(3)) dut_a (
    .Clk(Clk), .Reset(Reset), .key_valid(key_valid), .key_make(key_make),
    .key_code(key_code), .frame_tick(frame_tick), .keycode(keycode_a),
    .key_count(key_count_a), .overflow(overflow_a)
  );

  key_tracker #(.FILTER_EN(1'b0), .FRAME_TIMEOUT(120)) dut_b (
    .Clk(Clk), .Reset(Reset), .key_valid(key_valid), .key_make(key_make),
    .key_code(key_code), .frame_tick(frame_tick), .keycode(keycode_b),
    .key_count(key_count_b), .overflow(overflow_b)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_wasd(input logic [7:0] c);
    return c == 8'h1A || c == 8'h04 || c == 8'h16 || c == 8'h07;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      held[m].delete();
      ovf[m]  = 1'b0;
      idle[m] = 0;
      pub[m]  = 16'h0000;
    end
  endtask

  task automatic model_step(input int m, input bit v, input bit mk, input logic [7:0] c,
                            input bit t);
    int idx;
    idx = -1;
    for (int i = 0; i < held[m].size(); i++) if (held[m][i] == c) idx = i;
    if (v && c != 8'h00 && (!filt[m] || is_wasd(c))) begin
      idle[m] = 0;
      if (mk) begin
        if (idx < 0) begin
          if (held[m].size() < 2) held[m].push_back(c);
          else                    ovf[m] = 1'b1;
        end
      end else if (idx >= 0) begin
        held[m].delete(idx);
      end
    end else if (t && held[m].size() > 0) begin
      idle[m]++;
      if (idle[m] == tmo[m]) begin
        held[m].delete();
        idle[m] = 0;
      end
    end
    if (held[m].size() == 0) ovf[m] = 1'b0;
    if (t) pub[m] = {(held[m].size() > 1) ? held[m][1] : 8'h00,
                     (held[m].size() > 0) ? held[m][0] : 8'h00};
  endtask

  task automatic check_all(input string tag);
    check({tag, "/a.keycode"},   keycode_a,           pub[0]);
    check({tag, "/a.key_count"}, {14'd0, key_count_a}, 16'(held[0].size()));
    check({tag, "/a.overflow"},  {15'd0, overflow_a},  {15'd0, ovf[0]});
    check({tag, "/b.keycode"},   keycode_b,           pub[1]);
    check({tag, "/b.key_count"}, {14'd0, key_count_b}, 16'(held[1].size()));
    check({tag, "/b.overflow"},  {15'd0, overflow_b},  {15'd0, ovf[1]});
  endtask

  // One clock: drive inputs just after an edge, advance the model, sample 1 unit after the next edge.
  task automatic step(input string tag, input bit v, input bit mk, input logic [7:0] c,
                      input bit t);
    key_valid  = v;
    key_make   = mk;
    key_code   = c;
    frame_tick = t;
    for (int m = 0; m < 2; m++) model_step(m, v, mk, c, t);
    @(posedge Clk);
    #1;
    key_valid  = 1'b0;
    key_make   = 1'b0;
    key_code   = 8'h00;
    frame_tick = 1'b0;
    check_all(tag);
  endtask

  task automatic press(input string tag, input logic [7:0] c);
    step(tag, 1'b1, 1'b1, c, 1'b0);
  endtask

  task automatic release_key(input string tag, input logic [7:0] c);
    step(tag, 1'b1, 1'b0, c, 1'b0);
  endtask

  task automatic tick(input string tag);
    step(tag, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    model_reset();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [7:0] rc;
    key_valid = 1'b0; key_make = 1'b0; key_code = 8'h00; frame_tick = 1'b0;
    Reset = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Fill order and publication only on tick.
    press("p04", 8'h04);
    check("p04_not_yet_published", keycode_a, 16'h0000);
    tick("t1");
    check("one_key", keycode_a, 16'h0004);
    press("p1A", 8'h1A);
    tick("t2");
    check("two_keys", keycode_b, 16'h1A04);

    // Compaction on release of slot0.
    release_key("r04", 8'h04);
    tick("t3");
    check("compacted", keycode_a, 16'h001A);
    release_key("r1A", 8'h1A);
    tick("t4");
    check("empty", keycode_b, 16'h0000);

    // Overflow is sticky until both slots empty.
    press("p07", 8'h07);
    press("p16", 8'h16);
    press("p04_drop", 8'h04);
    check("overflow_set", {15'd0, overflow_a}, 16'h0001);
    release_key("r07", 8'h07);
    release_key("r16", 8'h16);
    tick("t5");
    check("overflow_clear", {15'd0, overflow_b}, 16'h0000);

    // Filter, release of unheld key, and auto-repeat restarting the idle count.
    press("p2C", 8'h2C);
    press("p07a", 8'h07);
    release_key("r1A_unheld", 8'h1A);
    tick("t6");
    tick("t7");
    press("p07_repeat", 8'h07);
    tick("t8");
    tick("t9");
    check("repeat_kept", keycode_a, 16'h0007);
    tick("t10_timeout");
    check("timed_out", keycode_a, 16'h0000);
    release_key("r07b", 8'h07);
    press("p00_ignored", 8'h00);

    // Timeout on the third tick, then an event coinciding with that tick cancels it.
    press("p16b", 8'h16);
    tick("to1");
    tick("to2");
    tick("to3");
    check("to_cleared", keycode_a, 16'h0000);
    release_key("r16b", 8'h16);
    press("p16c", 8'h16);
    tick("tc1");
    tick("tc2");
    step("tc3_with_press", 1'b1, 1'b1, 8'h16, 1'b1);
    check("to_cancelled", keycode_a, 16'h0016);
    release_key("r16c", 8'h16);

    // Asynchronous reset mid-cycle while holding two keys.
    press("p1Ab", 8'h1A);
    press("p07c", 8'h07);
    step("tr", 1'b0, 1'b0, 8'h00, 1'b1);
    #3;
    Reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    step("post_reset", 1'b1, 1'b1, 8'h04, 1'b1);
    check("post_reset_key", keycode_a, 16'h0004);
    do_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 7))
        0: rc = 8'h1A;
        1: rc = 8'h04;
        2: rc = 8'h16;
        3: rc = 8'h07;
        4: rc = 8'h00;
        5: rc = 8'h2C;
        default: rc = 8'($urandom_range(1, 255));
      endcase
      step("rand", ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) != 0), rc,
           ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
